// File: rtl/arbitro_vc_pkg.sv
// Shared encodings for the two-VC arbiter and its destination demux.
// No logic; constants and types only.
// No flow control of its own.
package arbitro_vc_pkg;

    localparam int DATA_WIDTH_DEF = 10;
    localparam int CLASS_W        = 2;
    localparam int CLASS_MSB      = DATA_WIDTH_DEF - 1;
    localparam int CLASS_LSB      = DATA_WIDTH_DEF - CLASS_W;

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } main_state_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_VC0  = 2'd1,
        ARB_VC1  = 2'd2
    } arb_state_t;

    function automatic logic [3:0] one_hot_dest(input logic [CLASS_W-1:0] d);
        return 4'b0001 << d;
    endfunction

endpackage

// File: rtl/demux_destino.sv
// Registered 1-to-4 steer of a word to the destination selected by its class.
// Latency 1 cycle: valid in N gives a one-hot push_d and data_out in N+1.
// No backpressure; the caller only asserts valid when the destination has room.
module demux_destino
    import arbitro_vc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [CLASS_W-1:0]    class_sel,
    input  logic [DATA_WIDTH-1:0] word,
    output logic [3:0]            push_d,
    output logic [DATA_WIDTH-1:0] data_out
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_d   <= 4'b0000;
            data_out <= '0;
        end else if (valid) begin
            push_d   <= one_hot_dest(class_sel);
            data_out <= word;
        end else begin
            push_d   <= 4'b0000;
        end
    end

endmodule

// File: rtl/arbitro_vc.sv
// Weighted two-VC arbiter popping FWFT VC FIFOs into four destination FIFOs.
// Latency 1 cycle: combinational pop in N, registered push in N+1; one word/cycle.
// A VC waits while its head's destination is almost full (head-of-line blocking).
module arbitro_vc
    import arbitro_vc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int VC0_WEIGHT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            state,
    input  logic                  empty_vc0,
    input  logic                  empty_vc1,
    input  logic [DATA_WIDTH-1:0] data_vc0,
    input  logic [DATA_WIDTH-1:0] data_vc1,
    input  logic [3:0]            almost_full_d,
    output logic                  pop_vc0,
    output logic                  pop_vc1,
    output logic [3:0]            push_d,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  idle
);

    logic                  active;
    logic [CLASS_W-1:0]    dest_vc0, dest_vc1, dest_sel;
    logic                  elig_vc0, elig_vc1;
    logic                  grant_vc0, grant_vc1;
    logic [3:0]            wcnt;
    logic [DATA_WIDTH-1:0] word_sel;
    arb_state_t            arb_state, arb_next;

    assign active   = (state == ST_ACTIVE);
    assign dest_vc0 = data_vc0[DATA_WIDTH-1 -: CLASS_W];
    assign dest_vc1 = data_vc1[DATA_WIDTH-1 -: CLASS_W];

    // reset is folded into eligibility so pops drop the moment reset rises
    assign elig_vc0 = active & ~empty_vc0 & ~almost_full_d[dest_vc0] & ~reset;
    assign elig_vc1 = active & ~empty_vc1 & ~almost_full_d[dest_vc1] & ~reset;

    assign grant_vc0 = elig_vc0 & (~elig_vc1 | (wcnt != 4'(VC0_WEIGHT)));
    assign grant_vc1 = elig_vc1 & ~grant_vc0;

    assign pop_vc0  = grant_vc0;
    assign pop_vc1  = grant_vc1;
    assign word_sel = grant_vc1 ? data_vc1 : data_vc0;
    assign dest_sel = grant_vc1 ? dest_vc1 : dest_vc0;

    always_comb begin
        arb_next = ARB_IDLE;
        case (arb_state)
            ARB_IDLE, ARB_VC0, ARB_VC1: begin
                if (grant_vc0)      arb_next = ARB_VC0;
                else if (grant_vc1) arb_next = ARB_VC1;
            end
            default: arb_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt      <= 4'd0;
            arb_state <= ARB_IDLE;
            idle      <= 1'b1;
        end else begin
            if (!active || grant_vc1 || !elig_vc1)
                wcnt <= 4'd0;
            else if (grant_vc0)
                wcnt <= wcnt + 4'd1;
            arb_state <= arb_next;
            idle      <= empty_vc0 & empty_vc1 & (arb_next == ARB_IDLE);
        end
    end

    demux_destino #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_demux (
        .clk       (clk),
        .reset     (reset),
        .valid     (grant_vc0 | grant_vc1),
        .class_sel (dest_sel),
        .word      (word_sel),
        .push_d    (push_d),
        .data_out  (data_out)
    );

endmodule

// File: tb/tb_arbitro_vc.sv
// Directed and lightly randomised bench for arbitro_vc with FWFT VC queue models
// and destination FIFO occupancy models.
module tb_arbitro_vc;
    import arbitro_vc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] state;
    logic       empty_vc0, empty_vc1;
    logic [9:0] data_vc0, data_vc1;
    logic [3:0] almost_full_d;
    logic       pop_vc0, pop_vc1;
    logic [3:0] push_d;
    logic [9:0] data_out;
    logic       idle;

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    arbitro_vc #(.DATA_WIDTH(10), .VC0_WEIGHT(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .state         (state),
        .empty_vc0     (empty_vc0),
        .empty_vc1     (empty_vc1),
        .data_vc0      (data_vc0),
        .data_vc1      (data_vc1),
        .almost_full_d (almost_full_d),
        .pop_vc0       (pop_vc0),
        .pop_vc1       (pop_vc1),
        .push_d        (push_d),
        .data_out      (data_out),
        .idle          (idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic heads();
        empty_vc0 = (q0.size() == 0);
        empty_vc1 = (q1.size() == 0);
        data_vc0  = (q0.size() != 0) ? q0[0] : 10'h0;
        data_vc1  = (q1.size() != 0) ? q1[0] : 10'h0;
        #1;
    endtask

    // one clock: capture pops before the edge, retire popped heads after it
    task automatic cyc();
        logic p0, p1;
        #1;
        p0 = pop_vc0;
        p1 = pop_vc1;
        @(posedge clk);
        if (p0 && q0.size() != 0) void'(q0.pop_front());
        if (p1 && q1.size() != 0) void'(q1.pop_front());
        #1;
        heads();
    endtask

    task automatic drain();
        q0.delete();
        q1.delete();
        heads();
        cyc();
        cyc();
    endtask

    bit         pat_w[10] = '{0,0,0,0,1,0,0,0,0,1};
    bit         pat_r[5]  = '{0,0,0,0,1};
    logic [9:0] exp_w;
    int         cnt[4];
    logic [6:0] seq_tx[2];
    logic [6:0] seq_rx[2];

    initial begin
        reset = 1'b1;
        state = ST_ACTIVE;
        almost_full_d = 4'b0000;
        heads();
        #12;
        chk("rst_push", push_d, 4'b0000);
        chk("rst_data", data_out, 10'h0);
        chk("rst_idle", idle, 1'b1);
        q0.push_back(10'h005);
        heads();
        chk("rst_pop_gate", pop_vc0, 1'b0);
        q0.delete();
        heads();
        @(negedge clk);
        reset = 1'b0;
        cyc();
        cyc();
        chk("idle_after_rst", idle, 1'b1);

        // single word, class 0
        q0.push_back(10'h005);
        heads();
        chk("t1_pop0", pop_vc0, 1'b1);
        chk("t1_pop1", pop_vc1, 1'b0);
        cyc();
        chk("t1_push", push_d, 4'b0001);
        chk("t1_data", data_out, 10'h005);
        chk("t1_idle_low", idle, 1'b0);
        chk("t1_no_pop", pop_vc0, 1'b0);
        cyc();
        chk("t1_push_end", push_d, 4'b0000);
        chk("t1_idle_high", idle, 1'b1);

        // weighted grant pattern, everything class 1
        for (int i = 0; i < 12; i++) begin
            q0.push_back(10'h100 + 10'(i));
            q1.push_back(10'h180 + 10'(i));
        end
        heads();
        for (int i = 0; i < 10; i++) begin
            chk("w_pop0", pop_vc0, !pat_w[i]);
            chk("w_pop1", pop_vc1, pat_w[i]);
            exp_w = pat_w[i] ? q1[0] : q0[0];
            cyc();
            chk("w_push", push_d, 4'b0010);
            chk("w_data", data_out, exp_w);
        end
        drain();

        // head-of-line blocking on destination 3
        q0.push_back(10'h305);
        q1.push_back(10'h105);
        almost_full_d = 4'b1000;
        heads();
        chk("hol_pop0", pop_vc0, 1'b0);
        chk("hol_pop1", pop_vc1, 1'b1);
        cyc();
        chk("hol_push", push_d, 4'b0010);
        chk("hol_data", data_out, 10'h105);
        chk("hol_wait", pop_vc0, 1'b0);
        cyc();
        chk("hol_push_idle", push_d, 4'b0000);
        almost_full_d = 4'b0000;
        heads();
        chk("hol_release", pop_vc0, 1'b1);
        cyc();
        chk("hol_push3", push_d, 4'b1000);
        chk("hol_data3", data_out, 10'h305);
        drain();

        // leave ACTIVE right after a pop, then resume with a cleared weight counter
        for (int i = 0; i < 7; i++) q0.push_back(10'h200 + 10'(i));
        for (int i = 0; i < 3; i++) q1.push_back(10'h000 + 10'(i));
        heads();
        chk("st_pop_a", pop_vc0, 1'b1);
        cyc();
        chk("st_pop_b", pop_vc0, 1'b1);
        cyc();
        state = ST_IDLE;
        heads();
        chk("st_push_kept", push_d, 4'b0100);
        chk("st_data_kept", data_out, 10'h201);
        chk("st_no_pop0", pop_vc0, 1'b0);
        chk("st_no_pop1", pop_vc1, 1'b0);
        cyc();
        chk("st_push_none", push_d, 4'b0000);
        state = ST_ACTIVE;
        heads();
        for (int i = 0; i < 5; i++) begin
            chk("st_resume_pop0", pop_vc0, !pat_r[i]);
            cyc();
        end
        drain();

        // asynchronous reset with a push pending
        q0.push_back(10'h3AA);
        q0.push_back(10'h3AB);
        heads();
        cyc();
        chk("ar_pending", push_d, 4'b1000);
        #2 reset = 1'b1;
        #1;
        chk("ar_push_clr", push_d, 4'b0000);
        chk("ar_data_clr", data_out, 10'h0);
        chk("ar_pop_gate", pop_vc0, 1'b0);
        cyc();
        chk("ar_pop_held", pop_vc0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("ar_resume_pop", pop_vc0, 1'b1);
        cyc();
        chk("ar_resume_push", push_d, 4'b1000);
        chk("ar_resume_data", data_out, 10'h3AB);
        drain();

        // random traffic into depth-4 destinations that flag almost-full at 3
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        seq_tx[0] = 7'd0; seq_tx[1] = 7'd0;
        seq_rx[0] = 7'd0; seq_rx[1] = 7'd0;
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 4; i++) almost_full_d[i] = (cnt[i] >= 3);
            if (q0.size() < 4 && $urandom_range(0, 3) != 0) begin
                q0.push_back({2'($urandom_range(0, 3)), 1'b0, seq_tx[0]});
                seq_tx[0] = seq_tx[0] + 7'd1;
            end
            if (q1.size() < 4 && $urandom_range(0, 3) != 0) begin
                q1.push_back({2'($urandom_range(0, 3)), 1'b1, seq_tx[1]});
                seq_tx[1] = seq_tx[1] + 7'd1;
            end
            heads();
            cyc();
            for (int i = 0; i < 4; i++) begin
                if (push_d[i]) begin
                    chk("rnd_no_overflow", 32'(cnt[i] < 4), 1);
                    chk("rnd_dest", data_out[9:8], i);
                    chk("rnd_order", data_out[6:0], seq_rx[data_out[7]]);
                    seq_rx[data_out[7]] = data_out[6:0] + 7'd1;
                    cnt[i]++;
                end
                if (cnt[i] > 0 && $urandom_range(0, 2) == 0) cnt[i]--;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/arbitro_vc.md
# arbitro_vc

Two-VC arbiter that sits directly downstream of the pair of VC FIFOs (VC0, VC1) in the transaction layer. It pops words from whichever VC FIFO wins arbitration. Each word is steered by its class field to one of four destination FIFOs, subject to per-destination backpressure. It is active only while the main control FSM is in ACTIVE.

## Interface
Parameters:
- DATA_WIDTH, 10, word width; class field is bits [DATA_WIDTH-1:DATA_WIDTH-2]
- VC0_WEIGHT, 4, maximum consecutive VC0 grants while VC1 is eligible and waiting (range 1..15)

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- state  in  4  main FSM state, one-hot: RESET=0001, INIT=0010, IDLE=0100, ACTIVE=1000
- empty_vc0, empty_vc1  in  1 each  upstream FIFO empty flags
- data_vc0, data_vc1  in  DATA_WIDTH each  upstream head word, first-word-fall-through, valid whenever the matching empty flag is 0
- almost_full_d  in  4  destination FIFO almost_full flags, bit i = destination i
- pop_vc0, pop_vc1  out  1 each  combinational pop to upstream FIFOs
- push_d  out  4  registered one-hot push to destinations
- data_out  out  DATA_WIDTH  registered word, shared by all destinations
- idle  out  1  registered; high when both VCs are empty and no push is in flight

## Operation
- Destination of a VC head word = its class field (bits [9:8] at default width), giving d = 0..3.
- eligible_vcX = ACTIVE & !empty_vcX & !almost_full_d[d(data_vcX)] & !reset.
- Grant rule, evaluated every cycle; at most one pop per cycle:
  - Only VC0 eligible: grant VC0.
  - Only VC1 eligible: grant VC1.
  - Both eligible: grant VC0 unless wcnt == VC0_WEIGHT, in which case grant VC1.
- Weight counter wcnt (4 bits):
  - Increments on a VC0 grant while VC1 is eligible.
  - Clears on any VC1 grant, or when VC1 is not eligible.
  - Clears whenever state != ACTIVE.
- Arbiter FSM, tracked by a 2-bit register:
  - ARB_IDLE -> ARB_VC0 or ARB_VC1 on a grant.
  - ARB_VC0 <-> ARB_VC1 follows the grant.
  - Any state -> ARB_IDLE when there is no grant.
  - The FSM drives idle and debug only; the grant itself is combinational.
- Pops are suppressed entirely in RESET, INIT and IDLE. A push already registered still completes.
- Head-of-line blocking is intended: a VC whose head targets an almost-full destination waits, and the other VC may proceed.
- No data transformation; data_out = popped word.

## Timing
- Reset values: push_d=0000, data_out=0, idle=1, wcnt=0, FSM=ARB_IDLE. pop_vc0/pop_vc1 are 0 while reset is high (gated combinationally).
- Latency: pop in cycle N -> push_d[d] and data_out valid in cycle N+1, for exactly one cycle.
- Throughput: one word per cycle sustained.
- Backpressure slack: almost_full is sampled in cycle N but the push lands in N+1. Destination thresholds (umbral_superior) must leave at least one free slot after almost_full asserts. The arbiter never pushes into a full FIFO under that rule.
- Simultaneous events:
  - Both VCs eligible to the same destination: only the winner pops.
  - almost_full rising in the same cycle as a head becomes valid: no pop.
- State leaves ACTIVE mid-stream: no pop from that cycle on; the pending push in N+1 still occurs.
- Reset mid-stream: push_d and data_out clear immediately (asynchronously). An in-flight word is dropped, and the upstream FIFO has already consumed it.
- idle falls the cycle after any VC becomes non-empty. It rises the cycle after the last push with both VCs empty.

## Structure
- Shared package: state encodings (RESET, INIT, IDLE, ACTIVE), DATA_WIDTH default, class-field MSB/LSB positions, arbiter FSM encodings.
- One sub-module: demux_destino. It is a registered 1-to-4 steer: inputs valid, class, word; outputs push_d[3:0], data_out. It is reused by the downstream demux stage.
- Grant logic, wcnt and the FSM remain in arbitro_vc.

## Test plan
- Reset then ACTIVE. VC0 holds 0x005 (class 0) and VC1 is empty -> pop_vc0 in cycle N; push_d=0001 and data_out=0x005 in N+1; idle returns to 1 in N+2.
- Both VCs continuously non-empty, all classes 1, no backpressure, VC0_WEIGHT=4 -> grant pattern VC0×4, VC1, VC0×4, VC1…; push_d=0010 every cycle.
- VC0 head 0x305 (class 3) with almost_full_d[3]=1, VC1 head 0x105 -> only VC1 pops. When almost_full_d[3] drops, VC0 pops the next cycle and push_d=1000.
- state switched ACTIVE -> IDLE in the cycle after a pop -> that push still appears and there are no further pops. Returning to ACTIVE resumes with wcnt=0.
- reset asserted asynchronously mid-cycle while a push is pending -> push_d=0000 and data_out=0 before the next edge; pops stay 0 until reset is released.
- Random traffic with the destination FIFO models (umbral_superior leaving one-slot slack) -> no push to a full destination, and per-VC word order is preserved at each destination.
